// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline control logic:
//   - ctrl_state_e   : hazard sequencer FSM state (RUN, MEM_WAIT, ERR)
//   - REG_AW         : architectural register index width
//   - stage_ctrl_t   : bundle of every pipeline-register enable and flush
//   - CTRL_* consts  : canonical control patterns, including the bubble
//                      encoding driven while the pipeline is held in reset
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_e;

  // Enables first, then flushes; a flush loads a bubble (all control fields 0).
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  // Control fields carried by a bubble inside a pipeline register.
  localparam logic BUBBLE_CTRL = 1'b0;

  // Normal flow: every stage advances, nothing squashed.
  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0
  };

  // Bubble everywhere: the next edge loads a bubble into every stage register.
  localparam stage_ctrl_t CTRL_BUBBLE_ALL = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b1
  };

  // Data-memory wait: front of the pipe holds, WB receives a bubble.
  localparam stage_ctrl_t CTRL_MEM_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b1
  };

  // Error: everything holds, nothing is squashed, so state stays inspectable.
  localparam stage_ctrl_t CTRL_HALT = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0
  };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard sequencer's pipeline-facing signals.
//   master : the pipeline datapath (drives hazard inputs, receives controls)
//   slave  : pipe_hazard_ctrl
// Inputs to the sequencer:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : source regs of the ID instruction
//   ex_rd, ex_load, ex_br_taken          : EX instruction info
//   mem_req, dm_ready                    : data-memory access / completion
// Outputs from the sequencer:
//   pc_en, *_en, *_flush : pipeline register enables and bubble loads
//   mem_timeout          : sticky data-memory timeout flag
//   stall_cycles         : saturating count of cycles with pc_en=0
//   ctrl_state           : FSM state for debug
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_pkg::*;

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_load;
  logic              ex_br_taken;
  logic              mem_req;
  logic              dm_ready;

  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              memwb_flush;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;
  logic [1:0]        ctrl_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_br_taken,
           mem_req, dm_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, ctrl_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_br_taken,
           mem_req, dm_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, ctrl_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in ID
// reads the destination of a load currently in EX. x0 never hazards.
// Ports:
//   i_id_rs1, i_id_rs2         : ID source register indices
//   i_id_use_rs1, i_id_use_rs2 : ID instruction actually reads that source
//   i_ex_rd                    : EX destination register index
//   i_ex_load                  : EX instruction is a load
//   o_load_use                 : load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_load,
  output logic              o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_nonzero;

  assign w_rs1_hit    = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit    = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign w_rd_nonzero = (i_ex_rd != '0);

  assign o_load_use = i_ex_load && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Drives the enable
// and flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Priority: data-memory wait > taken branch > load-use.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : pipe_hazard_ctrl_if.slave (hazard inputs, stage controls,
//          mem_timeout, stall_cycles, ctrl_state)
// Parameters:
//   MEM_TIMEOUT : max consecutive data-memory wait cycles before ERR
//   CNT_W       : stall_cycles width (must match the interface CNT_W)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_timeout;
  logic              w_mem_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic              w_load_use;
  logic              w_mem_stall;
  stage_ctrl_t       w_ctrl;

  hazard_detect u_hazard_detect (
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_id_use_rs1 (bus.id_use_rs1),
    .i_id_use_rs2 (bus.id_use_rs2),
    .i_ex_rd      (bus.ex_rd),
    .i_ex_load    (bus.ex_load),
    .o_load_use   (w_load_use)
  );

  // In MEM_WAIT the access is already outstanding, so only dm_ready matters.
  always_comb begin
    w_mem_stall = 1'b0;
    if (r_state == RUN) begin
      w_mem_stall = bus.mem_req && !bus.dm_ready;
    end else if (r_state == MEM_WAIT) begin
      w_mem_stall = !bus.dm_ready;
    end
  end

  always_comb begin
    w_ctrl            = CTRL_RUN;
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;

    if (rst) begin
      w_ctrl = CTRL_BUBBLE_ALL;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_mem_stall) begin
            w_ctrl = CTRL_MEM_FREEZE;
            if (r_state == RUN) begin
              w_state_nxt    = MEM_WAIT;
              w_wait_cnt_nxt = WAIT_W'(1);
            end else if (r_wait_cnt == WAIT_LAST) begin
              w_state_nxt       = ERR;
              w_mem_timeout_nxt = 1'b1;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
          end else begin
            // Branch squashes the ID instruction, so its load-use is moot.
            if (bus.ex_br_taken) begin
              w_ctrl.ifid_flush = 1'b1;
              w_ctrl.idex_flush = 1'b1;
            end else if (w_load_use) begin
              w_ctrl.pc_en      = 1'b0;
              w_ctrl.ifid_en    = 1'b0;
              w_ctrl.idex_flush = 1'b1;
            end
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
          end
        end
        ERR: begin
          w_ctrl = CTRL_HALT;
        end
        default: begin
          // Unreachable encoding: halt for one cycle and recover to RUN.
          w_ctrl         = CTRL_HALT;
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
      if (!w_ctrl.pc_en && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = w_ctrl.pc_en;
  assign bus.ifid_en      = w_ctrl.ifid_en;
  assign bus.idex_en      = w_ctrl.idex_en;
  assign bus.exmem_en     = w_ctrl.exmem_en;
  assign bus.memwb_en     = w_ctrl.memwb_en;
  assign bus.ifid_flush   = w_ctrl.ifid_flush;
  assign bus.idex_flush   = w_ctrl.idex_flush;
  assign bus.exmem_flush  = w_ctrl.exmem_flush;
  assign bus.memwb_flush  = w_ctrl.memwb_flush;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.ctrl_state   = r_state;

endmodule
